otu_map_ctrl: RTL and testbench
===============================

OTU_MAP_CTRL -- requirements
Module: otu_map_ctrl

Interface
REQ-001 SHALL have parameter START_LEVEL, default 64: the FIFO occupancy required before mapping starts.
REQ-002 SHALL have parameter MAX_STUFF, default 32: the stuffed-byte limit per frame before the block declares loss.
REQ-003 SHALL have parameter FILL_BYTE, default 8'h00: the byte inserted when no payload is available.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port i_enable, input, 1 bit: mapping enable; when low the block stalls.
REQ-007 SHALL have port i_fifo_level, input, 11 bits: client FIFO occupancy.
REQ-008 SHALL have port i_fifo_empty, input, 1 bit: client FIFO is empty.
REQ-009 SHALL have port i_fifo_data, input, 8 bits: first-word-fall-through head of the client FIFO.
REQ-010 SHALL have port o_fifo_rd, output, 1 bit: pops the FIFO head this cycle.
REQ-011 SHALL have port i_oh_data, input, 8 bits: the current overhead byte from the overhead generator.
REQ-012 SHALL have port o_oh_req, output, 1 bit: the overhead byte is consumed this cycle.
REQ-013 SHALL have port o_data, output, 8 bits: the mapped frame byte.
REQ-014 SHALL have port o_valid, output, 1 bit: o_data is valid.
REQ-015 SHALL have port o_sof, output, 1 bit: o_data is frame row 0, column 0.
REQ-016 SHALL have port o_stuff, output, 1 bit: o_data is FILL_BYTE.
REQ-017 SHALL have port o_row_cnt, output, 2 bits, and port o_col_cnt, output, 11 bits: the frame position of o_data.
REQ-018 SHALL have port o_loss, output, 1 bit: a one-cycle pulse when the block leaves RUN because of excess stuffing.
REQ-019 SHALL have port o_stuff_cnt, output, 16 bits: saturating total count of stuffed bytes.
REQ-020 SHALL have port o_state, output, 2 bits: IDLE=0, PRIME=1, RUN=2.

Function
REQ-021 SHALL treat each frame as 4 rows (0-3) by 1041 columns (0-1040); columns 0-15 are overhead, columns 16-1040 are payload.
REQ-022 SHALL advance the internal position by exactly one for each emitted byte: column 1040 wraps to column 0 with row+1, and row 3/column 1040 wraps to row 0/column 0.
REQ-023 SHALL emit one byte per cycle only when the state is RUN and i_enable=1; in all other cycles o_fifo_rd=0, o_oh_req=0, o_valid=0, and the position is held.
REQ-024 SHALL, at an overhead column, drive o_oh_req=1 combinationally and register i_oh_data onto o_data.
REQ-025 SHALL, at a payload column with i_fifo_empty=0, drive o_fifo_rd=1 combinationally and register i_fifo_data onto o_data with o_stuff=0.
REQ-026 SHALL, at a payload column with i_fifo_empty=1, keep o_fifo_rd=0, register FILL_BYTE onto o_data with o_stuff=1, and increment o_stuff_cnt (saturating at 16'hFFFF) and the per-frame stuff counter.
REQ-027 SHALL register o_data, o_valid, o_sof, o_stuff, o_row_cnt and o_col_cnt with 1-cycle latency from the emit cycle; o_row_cnt and o_col_cnt give the position of that byte.
REQ-028 SHALL never assert o_fifo_rd and o_oh_req in the same cycle.
REQ-029 SHALL transition IDLE->PRIME when i_enable=1.
REQ-030 SHALL transition PRIME->IDLE when i_enable=0.
REQ-031 SHALL transition PRIME->RUN when i_enable=1 and i_fifo_level>=START_LEVEL, with the position at row 0/column 0.
REQ-032 SHALL, in RUN with i_enable=0, stall in RUN with the position held, then resume at the held position when i_enable returns to 1.
REQ-033 SHALL, on emitting row 3/column 1040, compare the per-frame stuff count (including that byte) against MAX_STUFF.
REQ-034 SHALL, when that count is >MAX_STUFF, go to PRIME, pulse o_loss for 1 cycle, and reset the position to row 0/column 0.
REQ-035 SHALL, when that count is <=MAX_STUFF, stay in RUN and start the next frame.
REQ-036 SHALL clear the per-frame stuff counter at every frame wrap.
REQ-037 SHALL hold o_stuff_cnt across RUN/PRIME transitions; only reset clears it.

Reset
REQ-038 SHALL, while i_rst=1 (asynchronously), force state IDLE, position row 0/column 0, o_data=8'h00, o_valid=0, o_sof=0, o_stuff=0, o_loss=0, o_stuff_cnt=0, o_row_cnt=0, o_col_cnt=0.
REQ-039 SHALL, on reset asserted mid-frame, immediately drop o_fifo_rd and o_oh_req to 0.
REQ-040 SHALL, after reset is released, start the next frame at row 0/column 0 only through IDLE->PRIME->RUN.

Verification
REQ-041 Bench SHALL cover start-up: i_enable=1, i_fifo_level=63 then 64 -> RUN entered only at level 64; the first o_valid byte has o_sof=1, row 0, column 0.
REQ-042 Bench SHALL cover a full frame with the FIFO never empty: 4164 o_valid bytes; exactly 64 o_oh_req and 4100 o_fifo_rd; o_col_cnt 1040->0 with the row incrementing; the next byte has o_sof=1.
REQ-043 Bench SHALL cover i_fifo_empty=1 for 5 payload cycles -> 5 bytes of FILL_BYTE with o_stuff=1, o_stuff_cnt=5, no o_fifo_rd, and the position still advancing.
REQ-044 Bench SHALL cover 33 stuffed bytes in a frame (MAX_STUFF=32) -> o_loss pulses 1 cycle after the row 3/column 1040 byte, state=PRIME, and o_stuff_cnt is retained.
REQ-045 Bench SHALL cover i_enable low for 10 cycles at row 1/column 15 -> no strobes and o_valid=0 throughout; output resumes at row 1/column 15 and column 16 is a payload read.
REQ-046 Bench SHALL cover i_rst asserted at row 2/column 500 -> all outputs are at their reset values the same cycle, and after release the state is IDLE.

Source files
------------

// File: rtl/otu_map_ctrl.sv
// rtl/otu_map_ctrl.sv - maps client FIFO bytes and overhead into a 4x1041 frame with stuffing and loss detection
module otu_map_ctrl #(
  parameter int unsigned START_LEVEL = 64,
  parameter int unsigned MAX_STUFF   = 32,
  parameter logic [7:0]  FILL_BYTE   = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [10:0] i_fifo_level,
  input  logic        i_fifo_empty,
  input  logic [7:0]  i_fifo_data,
  output logic        o_fifo_rd,
  input  logic [7:0]  i_oh_data,
  output logic        o_oh_req,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_sof,
  output logic        o_stuff,
  output logic [1:0]  o_row_cnt,
  output logic [10:0] o_col_cnt,
  output logic        o_loss,
  output logic [15:0] o_stuff_cnt,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam logic [10:0] LAST_COL  = 11'd1040;
  localparam logic [10:0] OH_COLS   = 11'd16;
  localparam logic [10:0] START_LVL = 11'(START_LEVEL);
  // A frame holds 4100 payload bytes, so 13 bits cover any per-frame stuff count.
  localparam logic [12:0] MAX_STUFF_C = 13'(MAX_STUFF);

  state_t      state_q;
  logic [1:0]  row_q;
  logic [10:0] col_q;
  logic [12:0] frame_stuff_q;
  logic [12:0] frame_stuff_d;
  logic [15:0] stuff_cnt_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        sof_q;
  logic        stuff_q;
  logic        loss_q;
  logic [1:0]  row_cnt_q;
  logic [10:0] col_cnt_q;

  logic emit;
  logic at_oh;
  logic stuff_now;
  logic last_pos;

  // Strobes are combinational so the sources can pop in the same cycle; reset kills them at once.
  assign emit      = (state_q == S_RUN) && i_enable && !i_rst;
  assign at_oh     = (col_q < OH_COLS);
  assign o_oh_req  = emit && at_oh;
  assign o_fifo_rd = emit && !at_oh && !i_fifo_empty;
  assign stuff_now = emit && !at_oh && i_fifo_empty;
  assign last_pos  = (row_q == 2'd3) && (col_q == LAST_COL);

  // Per-frame stuff count including the byte emitted this cycle.
  assign frame_stuff_d = frame_stuff_q + {12'd0, stuff_now};

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_sof       = sof_q;
  assign o_stuff     = stuff_q;
  assign o_row_cnt   = row_cnt_q;
  assign o_col_cnt   = col_cnt_q;
  assign o_loss      = loss_q;
  assign o_stuff_cnt = stuff_cnt_q;
  assign o_state     = state_q;

  // Mapping FSM: state, frame position, stuff accounting and the registered output byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      row_q         <= 2'd0;
      col_q         <= 11'd0;
      frame_stuff_q <= 13'd0;
      stuff_cnt_q   <= 16'd0;
      data_q        <= 8'h00;
      valid_q       <= 1'b0;
      sof_q         <= 1'b0;
      stuff_q       <= 1'b0;
      loss_q        <= 1'b0;
      row_cnt_q     <= 2'd0;
      col_cnt_q     <= 11'd0;
    end else begin
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      stuff_q <= 1'b0;
      loss_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_enable) state_q <= S_PRIME;
        end
        S_PRIME: begin
          // Every entry into RUN starts a fresh frame.
          row_q         <= 2'd0;
          col_q         <= 11'd0;
          frame_stuff_q <= 13'd0;
          if (!i_enable) begin
            state_q <= S_IDLE;
          end else if (i_fifo_level >= START_LVL) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // With i_enable low nothing below fires, so the position simply holds.
          if (emit) begin
            valid_q   <= 1'b1;
            sof_q     <= (row_q == 2'd0) && (col_q == 11'd0);
            stuff_q   <= stuff_now;
            row_cnt_q <= row_q;
            col_cnt_q <= col_q;
            if (at_oh) begin
              data_q <= i_oh_data;
            end else if (i_fifo_empty) begin
              data_q <= FILL_BYTE;
            end else begin
              data_q <= i_fifo_data;
            end
            if (stuff_now && (stuff_cnt_q != 16'hFFFF)) begin
              stuff_cnt_q <= stuff_cnt_q + 16'd1;
            end
            if (last_pos) begin
              row_q         <= 2'd0;
              col_q         <= 11'd0;
              frame_stuff_q <= 13'd0;
              if (frame_stuff_d > MAX_STUFF_C) begin
                state_q <= S_PRIME;
                loss_q  <= 1'b1;
              end
            end else begin
              frame_stuff_q <= frame_stuff_d;
              if (col_q == LAST_COL) begin
                col_q <= 11'd0;
                row_q <= row_q + 2'd1;
              end else begin
                col_q <= col_q + 11'd1;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_otu_map_ctrl.sv
// tb/tb_otu_map_ctrl.sv - self-checking bench for otu_map_ctrl with a reference model and byte scoreboard
module tb_otu_map_ctrl;

  localparam logic [7:0] FILL = 8'hA5;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic [10:0] i_fifo_level;
  logic        i_fifo_empty;
  logic [7:0]  i_fifo_data;
  logic        o_fifo_rd;
  logic [7:0]  i_oh_data;
  logic        o_oh_req;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_sof;
  logic        o_stuff;
  logic [1:0]  o_row_cnt;
  logic [10:0] o_col_cnt;
  logic        o_loss;
  logic [15:0] o_stuff_cnt;
  logic [1:0]  o_state;

  otu_map_ctrl #(
    .START_LEVEL(64),
    .MAX_STUFF(32),
    .FILL_BYTE(FILL)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_enable(i_enable),
    .i_fifo_level(i_fifo_level),
    .i_fifo_empty(i_fifo_empty),
    .i_fifo_data(i_fifo_data),
    .o_fifo_rd(o_fifo_rd),
    .i_oh_data(i_oh_data),
    .o_oh_req(o_oh_req),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_sof(o_sof),
    .o_stuff(o_stuff),
    .o_row_cnt(o_row_cnt),
    .o_col_cnt(o_col_cnt),
    .o_loss(o_loss),
    .o_stuff_cnt(o_stuff_cnt),
    .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0]  data;
    logic        sof;
    logic        stuff;
    logic [1:0]  row;
    logic [10:0] col;
  } exp_t;

  typedef struct {
    logic        en;
    logic [10:0] lvl;
    logic        exp_oh;
    logic [1:0]  exp_state;
    logic        exp_valid;
    logic        exp_sof;
  } vec_t;

  exp_t  sbq[$];
  vec_t  vecs[8];

  int    passed = 0;
  int    total  = 0;
  int    sb_err = 0;
  string sb_first = "";

  logic [1:0]  m_state;
  int          m_row, m_col, m_fstuff;
  logic [15:0] m_total;
  logic        m_loss;

  int   valid_cnt, oh_cnt, rd_cnt, stuff_out_cnt, wraps, prev_col;
  logic last_pre_oh, last_pre_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic note(input string msg);
    if (sb_err == 0) sb_first = msg;
    sb_err++;
  endtask

  task automatic check_sb(input string name);
    total++;
    if (sb_err == 0) passed++;
    else $display("FAIL %s: %0d scoreboard errors, first: %s", name, sb_err, sb_first);
    sb_err   = 0;
    sb_first = "";
  endtask

  task automatic model_reset();
    m_state  = 2'd0;
    m_row    = 0;
    m_col    = 0;
    m_fstuff = 0;
    m_total  = 16'd0;
    m_loss   = 1'b0;
    sbq.delete();
  endtask

  // One clock: predict and check strobes before the edge, then check registered outputs after it.
  task automatic tick();
    logic emit, eoh, erd, est;
    exp_t e, g;
    #1;
    emit = (m_state == 2'd2) && i_enable;
    eoh  = emit && (m_col < 16);
    erd  = emit && (m_col >= 16) && !i_fifo_empty;
    est  = emit && (m_col >= 16) && i_fifo_empty;
    last_pre_oh = o_oh_req;
    last_pre_rd = o_fifo_rd;
    if (o_oh_req !== eoh) note($sformatf("oh_req %b exp %b at r%0d c%0d", o_oh_req, eoh, m_row, m_col));
    if (o_fifo_rd !== erd) note($sformatf("fifo_rd %b exp %b at r%0d c%0d", o_fifo_rd, erd, m_row, m_col));
    if (o_oh_req && o_fifo_rd) note("both strobes high");
    if (o_oh_req) oh_cnt++;
    if (o_fifo_rd) rd_cnt++;
    m_loss = 1'b0;
    case (m_state)
      2'd0: if (i_enable) m_state = 2'd1;
      2'd1: begin
        if (!i_enable) m_state = 2'd0;
        else if (i_fifo_level >= 11'd64) begin
          m_state = 2'd2; m_row = 0; m_col = 0; m_fstuff = 0;
        end
      end
      default: begin
        if (emit) begin
          e.data  = eoh ? i_oh_data : (erd ? i_fifo_data : FILL);
          e.sof   = (m_row == 0) && (m_col == 0);
          e.stuff = est;
          e.row   = 2'(m_row);
          e.col   = 11'(m_col);
          sbq.push_back(e);
          if (est) begin
            m_fstuff++;
            if (m_total != 16'hFFFF) m_total++;
          end
          if (m_row == 3 && m_col == 1040) begin
            if (m_fstuff > 32) begin
              m_state = 2'd1;
              m_loss  = 1'b1;
            end
            m_row = 0; m_col = 0; m_fstuff = 0;
          end else if (m_col == 1040) begin
            m_col = 0; m_row++;
          end else begin
            m_col++;
          end
        end
      end
    endcase
    @(posedge i_clk);
    #1;
    if (last_pre_rd) i_fifo_data = i_fifo_data + 8'd7;
    if (last_pre_oh) i_oh_data = i_oh_data + 8'd3;
    if (o_state !== m_state) note($sformatf("state %0d exp %0d", o_state, m_state));
    if (o_loss !== m_loss) note($sformatf("loss %b exp %b", o_loss, m_loss));
    if (o_stuff_cnt !== m_total) note($sformatf("stuff_cnt %0d exp %0d", o_stuff_cnt, m_total));
    if (o_valid) begin
      valid_cnt++;
      if (o_stuff) stuff_out_cnt++;
      if (prev_col == 1040 && o_col_cnt == 11'd0) wraps++;
      prev_col = int'(o_col_cnt);
      if (sbq.size() == 0) begin
        note($sformatf("unexpected valid at r%0d c%0d", o_row_cnt, o_col_cnt));
      end else begin
        g = sbq.pop_front();
        if (g.data !== o_data || g.sof !== o_sof || g.stuff !== o_stuff ||
            g.row !== o_row_cnt || g.col !== o_col_cnt)
          note($sformatf("byte got d%h sof%b st%b r%0d c%0d exp d%h sof%b st%b r%0d c%0d",
                         o_data, o_sof, o_stuff, o_row_cnt, o_col_cnt,
                         g.data, g.sof, g.stuff, g.row, g.col));
      end
    end else if (sbq.size() != 0) begin
      note("expected valid byte missing");
      sbq.delete();
    end
    @(negedge i_clk);
  endtask

  task automatic run_until(input int r, input int c, input string name);
    int n = 0;
    while (!(m_state == 2'd2 && m_row == r && m_col == c) && n < 6000) begin
      tick();
      n++;
    end
    check({name, "_reached"}, 32'(m_state == 2'd2 && m_row == r && m_col == c), 1);
  endtask

  task automatic run_to_last(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(o_valid && o_row_cnt == 2'd3 && o_col_cnt == 11'd1040) && n < 5000);
    check({name, "_last_byte"}, 32'(o_valid && o_row_cnt == 2'd3 && o_col_cnt == 11'd1040), 1);
  endtask

  task automatic check_reset(input string p);
    check({p, "_fifo_rd"}, 32'(o_fifo_rd), 0);
    check({p, "_oh_req"}, 32'(o_oh_req), 0);
    check({p, "_flags"}, 32'({o_valid, o_sof, o_stuff, o_loss}), 0);
    check({p, "_data"}, 32'(o_data), 0);
    check({p, "_stuff_cnt"}, 32'(o_stuff_cnt), 0);
    check({p, "_pos"}, 32'({o_row_cnt, o_col_cnt}), 0);
    check({p, "_state"}, 32'(o_state), 0);
  endtask

  initial begin
    int v0, r0, s0;
    vecs[0] = '{1'b0, 11'd0,  1'b0, 2'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 11'd63, 1'b0, 2'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 11'd63, 1'b0, 2'd1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 11'd63, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 11'd64, 1'b0, 2'd1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 11'd63, 1'b0, 2'd1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 11'd64, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 11'd64, 1'b1, 2'd2, 1'b1, 1'b1};

    i_rst = 1'b1; i_enable = 1'b0; i_fifo_level = 11'd0; i_fifo_empty = 1'b0;
    i_fifo_data = 8'h10; i_oh_data = 8'hF0;
    model_reset();
    valid_cnt = 0; oh_cnt = 0; rd_cnt = 0; stuff_out_cnt = 0; wraps = 0; prev_col = -1;
    repeat (2) @(negedge i_clk);
    check_reset("init");
    i_rst = 1'b0;

    // Start-up: RUN only from PRIME once the level reaches 64.
    for (int i = 0; i < 8; i++) begin
      i_enable     = vecs[i].en;
      i_fifo_level = vecs[i].lvl;
      tick();
      check($sformatf("vec%0d_oh_req", i), 32'(last_pre_oh), 32'(vecs[i].exp_oh));
      check($sformatf("vec%0d_state", i), 32'(o_state), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_sof", i), 32'(o_sof), 32'(vecs[i].exp_sof));
    end
    check("first_byte_pos", 32'({o_row_cnt, o_col_cnt}), 0);

    // Full frame with the FIFO never empty.
    begin
      int n = 0;
      while (valid_cnt < 4164 && n < 5000) begin
        tick();
        n++;
      end
    end
    check("frame_valid_cnt", 32'(valid_cnt), 4164);
    check("frame_oh_cnt", 32'(oh_cnt), 64);
    check("frame_rd_cnt", 32'(rd_cnt), 4100);
    check("frame_last_pos", 32'({o_row_cnt, o_col_cnt}), 32'({2'd3, 11'd1040}));
    tick();
    check("next_frame_sof", 32'(o_sof), 1);
    check("next_frame_pos", 32'({o_row_cnt, o_col_cnt}), 0);
    check("col_wraps", 32'(wraps), 4);
    check_sb("sb_startup_frame");

    // Five stuffed payload bytes.
    run_until(0, 20, "stuff5");
    check("stuff_cnt_before", 32'(o_stuff_cnt), 0);
    r0 = rd_cnt; s0 = stuff_out_cnt;
    i_fifo_empty = 1'b1;
    repeat (5) tick();
    check("stuff5_out_cnt", 32'(stuff_out_cnt - s0), 5);
    check("stuff5_no_rd", 32'(rd_cnt - r0), 0);
    check("stuff5_cnt", 32'(o_stuff_cnt), 5);
    check("stuff5_last_col", 32'(o_col_cnt), 24);
    check("stuff5_fill", 32'(o_data), 32'(FILL));
    i_fifo_empty = 1'b0;
    tick();
    check("after_stuff_flag", 32'(o_stuff), 0);
    check("after_stuff_col", 32'(o_col_cnt), 25);
    check_sb("sb_stuff5");

    // Exactly MAX_STUFF stuffed bytes in a frame is tolerated.
    run_until(1, 500, "stuff27");
    i_fifo_empty = 1'b1;
    repeat (27) tick();
    i_fifo_empty = 1'b0;
    run_to_last("frame32");
    check("frame32_no_loss", 32'(o_loss), 0);
    check("frame32_state", 32'(o_state), 2);
    check("frame32_stuff_cnt", 32'(o_stuff_cnt), 32);
    tick();
    check("frame32_next_sof", 32'(o_sof), 1);
    check_sb("sb_frame32");

    // Enable low for ten cycles at row 1 / column 15.
    run_until(1, 15, "stall");
    i_enable = 1'b0;
    v0 = valid_cnt; r0 = rd_cnt; s0 = oh_cnt;
    repeat (10) tick();
    check("stall_valid", 32'(valid_cnt - v0), 0);
    check("stall_strobes", 32'((rd_cnt - r0) + (oh_cnt - s0)), 0);
    check("stall_state", 32'(o_state), 2);
    i_enable = 1'b1;
    tick();
    check("resume_oh_req", 32'(last_pre_oh), 1);
    check("resume_pos", 32'({o_valid, o_row_cnt, o_col_cnt}), 32'({1'b1, 2'd1, 11'd15}));
    tick();
    check("resume_payload_rd", 32'(last_pre_rd), 1);
    check("resume_payload_pos", 32'({o_stuff, o_row_cnt, o_col_cnt}), 32'({1'b0, 2'd1, 11'd16}));
    check_sb("sb_stall");

    // 33 stuffed bytes in a frame triggers loss.
    run_until(2, 100, "stuff33");
    i_fifo_empty = 1'b1;
    repeat (33) tick();
    i_fifo_empty = 1'b0;
    run_to_last("frame33");
    check("frame33_loss", 32'(o_loss), 1);
    check("frame33_state", 32'(o_state), 1);
    check("frame33_stuff_cnt", 32'(o_stuff_cnt), 65);
    tick();
    check("loss_one_cycle", 32'(o_loss), 0);
    check("loss_stuff_cnt_held", 32'(o_stuff_cnt), 65);
    check("reprime_state", 32'(o_state), 2);
    check_sb("sb_loss");

    // Asynchronous reset mid-frame at row 2 / column 500.
    run_until(2, 500, "rst_point");
    check("pre_rst_fifo_rd", 32'(o_fifo_rd), 1);
    i_rst = 1'b1;
    #1;
    check_reset("midrst");
    @(posedge i_clk);
    @(negedge i_clk);
    model_reset();
    i_rst = 1'b0;
    #1;
    check("post_rst_state", 32'(o_state), 0);
    tick();
    check("post_rst_prime", 32'(o_state), 1);
    tick();
    check("post_rst_run", 32'(o_state), 2);
    tick();
    check("post_rst_sof", 32'({o_valid, o_sof, o_row_cnt, o_col_cnt}), 32'({1'b1, 1'b1, 2'd0, 11'd0}));
    check_sb("sb_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
